// File: rtl/if_fetch_pkg.sv
// Shared constants, state encoding and byte-lane helper for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int CTRL_WIDTH = 6;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam logic [2:0]  BYTES_PER_INST = 3'd4;

    typedef enum logic {
        FETCH = 1'b0,
        DONE  = 1'b1
    } fetch_state_t;

    // Little-endian lane insert: lane 0 is the byte at the lowest address.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] result;
        result = word;
        result[8*lane +: 8] = data;
        return result;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory port shared between the fetch stage and the memory arbiter.
interface if_fetch_if;

    logic        mem_busy_i;
    logic [7:0]  mem_data_i;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;

    modport master (
        input  mem_busy_i,
        input  mem_data_i,
        output mem_addr_o,
        output mem_rd_o
    );

    modport slave (
        output mem_busy_i,
        output mem_data_i,
        input  mem_addr_o,
        input  mem_rd_o
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four byte reads, then hands it to IF/ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CTRL_WIDTH-1:0] stall,
    input  logic                  branch_flag_i,
    input  logic [31:0]           branch_target_addr_i,
    if_fetch_if.master            mem,
    output logic                  req_if,
    output logic [31:0]           pc_o,
    output logic [31:0]           inst_o
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [2:0]   issue_idx, issue_idx_next;
    logic         pend, pend_next;
    logic [31:0]  byte_buf, byte_buf_next;

    logic         redirect;
    logic         issue;
    logic [2:0]   capture_idx;
    logic         unused_bits;

    assign redirect    = branch_flag_i && !stall[2];
    assign capture_idx = issue_idx - 3'd1;
    assign issue       = !rst && (state == FETCH) && (issue_idx < BYTES_PER_INST)
                         && !mem.mem_busy_i && !redirect;
    assign unused_bits = ^{stall[CTRL_WIDTH-1:3], stall[0], capture_idx[2]};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            issue_idx <= 3'd0;
            pend      <= 1'b0;
            byte_buf  <= NOP_INST;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            issue_idx <= issue_idx_next;
            pend      <= pend_next;
            byte_buf  <= byte_buf_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        issue_idx_next = issue_idx;
        pend_next      = pend;
        byte_buf_next  = byte_buf;

        case (state)
            FETCH: begin
                if (pend) begin
                    byte_buf_next = insert_byte(byte_buf, capture_idx[1:0], mem.mem_data_i);
                end
                if (issue) begin
                    issue_idx_next = issue_idx + 3'd1;
                    pend_next      = 1'b1;
                end else begin
                    pend_next      = 1'b0;
                end
                if ((issue_idx == BYTES_PER_INST) && pend) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!stall[1]) begin
                    pc_next        = pc + 32'd4;
                    issue_idx_next = 3'd0;
                    pend_next      = 1'b0;
                    state_next     = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase

        // A redirect drops any byte still returning, so the buffer is left untouched.
        if (redirect) begin
            pc_next        = branch_target_addr_i;
            state_next     = FETCH;
            issue_idx_next = 3'd0;
            pend_next      = 1'b0;
            byte_buf_next  = byte_buf;
        end
    end

    always_comb begin
        mem.mem_rd_o   = issue;
        mem.mem_addr_o = issue ? (pc + {29'd0, issue_idx}) : pc;
        req_if         = (!rst && (state == FETCH)) ? STOP : NO_STOP;
        pc_o           = pc;
        inst_o         = redirect ? NOP_INST : byte_buf;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [CTRL_WIDTH-1:0] stall;
    logic                  branch_flag_i;
    logic [31:0]           branch_target_addr_i;
    logic                  req_if;
    logic [31:0]           pc_o;
    logic [31:0]           inst_o;

    if_fetch_if mem_bus ();

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall                (stall),
        .branch_flag_i        (branch_flag_i),
        .branch_target_addr_i (branch_target_addr_i),
        .mem                  (mem_bus),
        .req_if               (req_if),
        .pc_o                 (pc_o),
        .inst_o               (inst_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_img [0:1023];
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_addr = 32'd0;

    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'd0;
    int          m_issued = 0;
    int          m_recv = 0;
    logic        m_done = 1'b0;
    logic        m_last_issue = 1'b0;
    int          handoffs = 0;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return mem_img[a[9:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a fetch is "issued count / received count" at the current pc; the word is read from the image.
    always @(negedge clk) begin : compare
        logic        redirect;
        logic        exp_rd;
        redirect = branch_flag_i && !stall[2];
        exp_rd   = 1'b0;
        if (rst) begin
            check_output("rst_rd", {31'd0, mem_bus.mem_rd_o}, 32'd0);
            check_output("rst_req", {31'd0, req_if}, 32'd0);
        end else if (m_valid) begin
            check_output("pc_o", pc_o, m_pc);
            if (!m_done) begin
                exp_rd = (m_issued < 4) && !mem_bus.mem_busy_i && !redirect;
                check_output("fetch_req", {31'd0, req_if}, 32'd1);
                check_output("fetch_rd", {31'd0, mem_bus.mem_rd_o}, {31'd0, exp_rd});
                if (exp_rd)
                    check_output("fetch_addr", mem_bus.mem_addr_o, m_pc + 32'(m_issued));
                if (redirect)
                    check_output("fetch_squash", inst_o, NOP_INST);
            end else begin
                check_output("done_req", {31'd0, req_if}, 32'd0);
                check_output("done_rd", {31'd0, mem_bus.mem_rd_o}, 32'd0);
                check_output("done_inst", inst_o, redirect ? NOP_INST : word_at(m_pc));
            end
        end

        rsp_valid = mem_bus.mem_rd_o;
        rsp_addr  = mem_bus.mem_addr_o;

        if (rst) begin
            m_valid = 1'b1; m_pc = RESET_PC; m_issued = 0; m_recv = 0;
            m_done = 1'b0; m_last_issue = 1'b0;
        end else if (m_valid) begin
            if (redirect) begin
                m_pc = branch_target_addr_i; m_issued = 0; m_recv = 0;
                m_done = 1'b0; m_last_issue = 1'b0;
            end else if (!m_done) begin
                if (m_last_issue) m_recv++;
                m_last_issue = exp_rd;
                if (exp_rd) m_issued++;
                if (m_recv == 4) m_done = 1'b1;
            end else if (!stall[1]) begin
                m_pc = m_pc + 32'd4; m_issued = 0; m_recv = 0;
                m_done = 1'b0; m_last_issue = 1'b0;
                handoffs++;
            end
        end
    end

    // Drives one cycle of inputs just after the edge and returns after the compare process has run.
    task automatic apply_stimulus(input logic r, input logic [5:0] s, input logic b,
                                  input logic [31:0] t, input logic busy);
        @(posedge clk);
        #1;
        rst                  = r;
        stall                = s;
        branch_flag_i        = b;
        branch_target_addr_i = t;
        mem_bus.mem_busy_i   = busy;
        mem_bus.mem_data_i   = rsp_valid ? byte_at(rsp_addr) : 8'($urandom);
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Runs with ID stalled until the instruction is complete, bounded so a stuck fetch still ends.
    task automatic run_until_done();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            apply_stimulus(1'b0, 6'b000010, 1'b0, 32'd0, 1'b0);
            if (req_if == 1'b0) found = 1'b1;
        end
        check_output("done_reached", {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [5:0]  s;
        logic [31:0] tgt;
        logic [31:0] held_inst;

        for (int i = 0; i < 1024; i++) mem_img[i] = 8'($urandom);
        mem_img[0]     = 8'h13; mem_img[1]     = 8'h05; mem_img[2]     = 8'h00; mem_img[3]     = 8'h00;
        mem_img[10'h100] = 8'h93; mem_img[10'h101] = 8'h00; mem_img[10'h102] = 8'h10; mem_img[10'h103] = 8'h00;
        mem_img[10'h200] = 8'h37; mem_img[10'h201] = 8'h45; mem_img[10'h202] = 8'h23; mem_img[10'h203] = 8'h01;

        rst = 1'b1; stall = '0; branch_flag_i = 1'b0; branch_target_addr_i = '0;
        mem_bus.mem_busy_i = 1'b0; mem_bus.mem_data_i = 8'd0;

        apply_stimulus(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            idle_cycle();
            check_output("c0_c4_req", {31'd0, req_if}, 32'd1);
        end

        // First instruction completes at c5; hold it with ID stalled for three cycles.
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b0, 6'b000111, 1'b0, 32'd0, 1'b0);
            check_output("stall_inst", inst_o, 32'h0000_0513);
            check_output("stall_pc", pc_o, 32'd0);
            check_output("stall_req", {31'd0, req_if}, 32'd0);
            check_output("stall_rd", {31'd0, mem_bus.mem_rd_o}, 32'd0);
        end
        idle_cycle();
        check_output("handoff_inst", inst_o, 32'h0000_0513);
        idle_cycle();
        check_output("next_addr", mem_bus.mem_addr_o, 32'd4);
        check_output("next_rd", {31'd0, mem_bus.mem_rd_o}, 32'd1);

        // Redirect while two bytes of the word at 4 have been issued.
        idle_cycle();
        apply_stimulus(1'b0, 6'd0, 1'b1, 32'h100, 1'b0);
        idle_cycle();
        check_output("redir_addr", mem_bus.mem_addr_o, 32'h100);
        check_output("redir_rd", {31'd0, mem_bus.mem_rd_o}, 32'd1);
        run_until_done();
        check_output("redir_inst", inst_o, 32'h0010_0093);
        check_output("redir_pc", pc_o, 32'h100);

        // Redirect coincident with handoff turns the delivered instruction into a bubble.
        apply_stimulus(1'b0, 6'd0, 1'b1, 32'h200, 1'b0);
        check_output("bubble_inst", inst_o, NOP_INST);
        idle_cycle();
        check_output("bubble_next_addr", mem_bus.mem_addr_o, 32'h200);

        // Two busy cycles after byte 1 push DONE from c5 to c7.
        idle_cycle();
        check_output("busy_b1_addr", mem_bus.mem_addr_o, 32'h201);
        for (int c = 0; c < 2; c++) begin
            apply_stimulus(1'b0, 6'd0, 1'b0, 32'd0, 1'b1);
            check_output("busy_rd", {31'd0, mem_bus.mem_rd_o}, 32'd0);
        end
        idle_cycle();
        check_output("busy_b2_addr", mem_bus.mem_addr_o, 32'h202);
        idle_cycle();
        check_output("busy_b3_addr", mem_bus.mem_addr_o, 32'h203);
        idle_cycle();
        check_output("busy_c6_req", {31'd0, req_if}, 32'd1);
        idle_cycle();
        check_output("busy_c7_req", {31'd0, req_if}, 32'd0);
        check_output("busy_c7_inst", inst_o, 32'h0123_4537);
        held_inst = inst_o;

        // Reset when three bytes of the word at 0x204 have been issued.
        for (int c = 0; c < 3; c++) idle_cycle();
        apply_stimulus(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        idle_cycle();
        check_output("rst_mid_req", {31'd0, req_if}, 32'd1);
        check_output("rst_mid_addr", mem_bus.mem_addr_o, RESET_PC);
        check_output("rst_mid_inst", inst_o, NOP_INST);
        check_output("rst_mid_pc", pc_o, RESET_PC);
        if (held_inst == NOP_INST) check_output("held_inst_real", held_inst, 32'h0123_4537);

        handoffs = 0;
        for (int c = 0; c < 3000; c++) begin
            s    = 6'($urandom);
            s[1] = ($urandom_range(0, 2) == 0);
            s[2] = ($urandom_range(0, 3) == 0);
            s[0] = s[1];
            case ($urandom_range(0, 3))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'hFFFF_FFFC;
                2:       tgt = 32'h0000_0200;
                default: tgt = $urandom;
            endcase
            apply_stimulus($urandom_range(0, 127) == 0, s, $urandom_range(0, 15) == 0, tgt,
                           $urandom_range(0, 3) == 0);
        end
        check_output("handoffs_seen", {31'd0, handoffs > 20}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
